// File: rtl/giant_mux.sv
// Registered 16-way function-select multiplexer: one of sixteen unary transforms
// of the operand is chosen by Selection and captured into Output every clock.
module giant_mux #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Input,
  input  logic [3:0]       Selection,
  output logic [WIDTH-1:0] Output
);

  localparam logic [WIDTH-1:0] unit = WIDTH'(1);

  typedef enum logic [3:0] {
    SEL_PASS   = 4'd0,
    SEL_NOT    = 4'd1,
    SEL_SHL    = 4'd2,
    SEL_SHR    = 4'd3,
    SEL_ASR    = 4'd4,
    SEL_ROL    = 4'd5,
    SEL_ROR    = 4'd6,
    SEL_NEG    = 4'd7,
    SEL_INC    = 4'd8,
    SEL_DEC    = 4'd9,
    SEL_REV    = 4'd10,
    SEL_POPCNT = 4'd11,
    SEL_CLZ    = 4'd12,
    SEL_ZERO   = 4'd13,
    SEL_ONES   = 4'd14,
    SEL_PASS2  = 4'd15
  } sel_e;

  logic [WIDTH-1:0] popcnt;
  logic [WIDTH-1:0] clz;
  logic [WIDTH-1:0] reversed;
  logic [WIDTH-1:0] result;

  // Bit-level helpers; the clz scan runs LSB upward so the highest set bit wins,
  // leaving WIDTH in place when the operand is all zeros.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    popcnt   = '0;
    clz      = WIDTH'(WIDTH);
    reversed = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt      = popcnt + {{(WIDTH-1){1'b0}}, Input[i]};
      reversed[i] = Input[WIDTH-1-i];
      if (Input[i]) clz = WIDTH'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    result = '0;
    case (sel_e'(Selection))
      SEL_PASS:   result = Input;
      SEL_NOT:    result = ~Input;
      SEL_SHL:    result = {Input[WIDTH-2:0], 1'b0};
      SEL_SHR:    result = {1'b0, Input[WIDTH-1:1]};
      SEL_ASR:    result = {Input[WIDTH-1], Input[WIDTH-1:1]};
      SEL_ROL:    result = {Input[WIDTH-2:0], Input[WIDTH-1]};
      SEL_ROR:    result = {Input[0], Input[WIDTH-1:1]};
      SEL_NEG:    result = ~Input + unit;
      SEL_INC:    result = Input + unit;
      SEL_DEC:    result = Input - unit;
      SEL_REV:    result = reversed;
      SEL_POPCNT: result = popcnt;
      SEL_CLZ:    result = clz;
      SEL_ZERO:   result = '0;
      SEL_ONES:   result = '1;
      SEL_PASS2:  result = Input;
      default:    result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    if (!rst_n) Output <= '0;
    else        Output <= result;
  end

endmodule

// File: tb/tb_giant_mux.sv
// Directed and randomized bench for giant_mux with immediate-assertion checks
// against an independent reference function.
module tb_giant_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [16:0] in_v = '0;
  logic [3:0]  sel_v = '0;
  logic [16:0] out_v;

  int checks = 0;
  int errors = 0;

  giant_mux #(.WIDTH(17)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .Input    (in_v),
    .Selection(sel_v),
    .Output   (out_v)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] ref_f(input logic [16:0] a, input logic [3:0] s);
    logic [16:0] r;
    logic [16:0] zero17;
    int k;
    zero17 = '0;
    r = '0;
    case (s)
      4'd0, 4'd15: r = a;
      4'd1:  r = a ^ 17'h1FFFF;
      4'd2:  r = a << 1;
      4'd3:  r = a >> 1;
      4'd4:  r = {a[16], a[16:1]};
      4'd5:  r = {a[15:0], a[16]};
      4'd6:  r = {a[0], a[16:1]};
      4'd7:  r = zero17 - a;
      4'd8:  r = a + 17'd1;
      4'd9:  r = a - 17'd1;
      4'd10: for (int i = 0; i < 17; i++) r[16-i] = a[i];
      4'd11: r = 17'($countones(a));
      4'd12: begin
        k = 0;
        while (k < 17 && !a[16-k]) k++;
        r = 17'(k);
      end
      4'd13: r = '0;
      4'd14: r = 17'h1FFFF;
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [16:0] exp);
    checks++;
    assert (out_v === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%05h expected 0x%05h", tag, out_v, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then sample 1 time unit after the next one.
  task automatic step(input logic [16:0] a, input logic [3:0] s, input string tag,
                      input logic [16:0] exp);
    in_v  = a;
    sel_v = s;
    @(posedge clk);
    #1;
    check(tag, exp);
  endtask

  logic [16:0] seq_exp [10];
  logic [16:0] ra;
  logic [3:0]  rs;
  logic [16:0] rexp;

  initial begin
    // 1. reset holds Output at zero across clock edges
    in_v  = 17'd42;
    sel_v = 4'd0;
    #1;
    check("reset_initial", 17'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_clocked", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_no_edge", 17'd0);
    @(posedge clk);
    #1;
    check("first_capture", 17'd42);

    // 2. Input=42, codes 1..10
    seq_exp = '{17'h1FFD5, 17'd84, 17'd21, 17'd21, 17'd84, 17'd21, 17'h1FFD6,
                17'd43, 17'd41, 17'h0A800};
    for (int i = 0; i < 10; i++)
      step(17'd42, 4'(i + 1), $sformatf("sel%0d_42", i + 1), seq_exp[i]);

    // 3. remaining codes on 42
    step(17'd42, 4'd11, "popcnt_42", 17'd3);
    step(17'd42, 4'd12, "clz_42",    17'd11);
    step(17'd42, 4'd13, "zero_42",   17'd0);
    step(17'd42, 4'd14, "ones_42",   17'h1FFFF);
    step(17'd42, 4'd15, "pass15_42", 17'd42);

    // 4. wrap and edge values
    step(17'h1FFFF, 4'd8,  "inc_wrap",   17'd0);
    step(17'h00000, 4'd9,  "dec_wrap",   17'h1FFFF);
    step(17'h10000, 4'd4,  "asr_msb",    17'h18000);
    step(17'h10000, 4'd5,  "rol_msb",    17'd1);
    step(17'h00000, 4'd7,  "neg_zero",   17'd0);
    step(17'h00000, 4'd12, "clz_zero",   17'd17);
    step(17'h00001, 4'd12, "clz_one",    17'd16);
    step(17'h1FFFF, 4'd11, "popcnt_all", 17'd17);
    step(17'h00001, 4'd6,  "ror_lsb",    17'h10000);

    // 5. asynchronous reset mid-cycle while Output is nonzero
    step(17'h1234, 4'd0, "pre_async", 17'h1234);
    in_v  = 17'h0BEEF;
    sel_v = 4'd1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 17'd0);
    @(posedge clk);
    #1;
    check("in_flight_dropped", 17'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_v  = 17'd7;
    sel_v = 4'd8;
    #1;
    check("release2_no_edge", 17'd0);
    @(posedge clk);
    #1;
    check("resume_capture", 17'd8);

    // 6. random inputs every cycle against the reference function
    for (int n = 0; n < 300; n++) begin
      ra   = 17'($urandom);
      rs   = 4'($urandom_range(0, 15));
      rexp = ref_f(ra, rs);
      step(ra, rs, $sformatf("rand%0d_sel%0d", n, rs), rexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
